// File: rtl/regfile_writeback.sv
// Writeback arbiter and register scoreboard for the 32-entry register file.
// It merges ALU results, buffered load returns and multi-cycle results onto
// the single write port. It also tracks destinations that still have a write
// outstanding, so issue logic can detect RAW hazards.
module regfile_writeback #(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    input  logic        issue_en,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_busy1,
    output logic        chk_busy2,
    output logic [4:0]  addrw,
    output logic [31:0] wdata,
    output logic        we
);
    localparam int AW = $clog2(LD_FIFO_DEPTH);

    // r0, r1 and r31 are hardwired in the register file and are never written
    function automatic logic is_hardwired(input logic [4:0] a);
        return (a == 5'd0) || (a == 5'd1) || (a == 5'd31);
    endfunction

    // Load-return FIFO: entry = {dest, data}; pointers carry one wrap bit
    logic [36:0] fifo_mem [LD_FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic        fifo_empty, fifo_full;
    logic        fifo_push, fifo_pop;
    logic [36:0] fifo_head;

    // Winner of this cycle's arbitration
    logic        win_valid;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        mc_take;
    logic        wr_ok;

    // Scoreboard
    logic [31:0] pending_reg, pending_next;
    logic [31:0] set_vec, clr_vec;

    // Output register
    logic        we_reg;
    logic [4:0]  addrw_reg;
    logic [31:0] wdata_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                        (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    // The head is read combinationally so it can win arbitration in the same
    // cycle it becomes visible; the FIFO is small enough for distributed storage.
    assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    // Ready depends only on state (and reset), so a same-cycle pop never raises it
    assign ld_ready  = rst && !fifo_full;
    assign fifo_push = ld_valid && ld_ready;
    assign mc_ready  = rst && mc_take;

    // Fixed-priority winner selection: ALU, then FIFO head, then multi-cycle
    always_comb begin
        win_valid = 1'b0;
        win_addr  = 5'd0;
        win_data  = 32'd0;
        fifo_pop  = 1'b0;
        mc_take   = 1'b0;
        if (alu_valid) begin
            win_valid = 1'b1;
            win_addr  = alu_addr;
            win_data  = alu_data;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_addr  = fifo_head[36:32];
            win_data  = fifo_head[31:0];
            fifo_pop  = 1'b1;
        end else if (mc_valid) begin
            win_valid = 1'b1;
            win_addr  = mc_addr;
            win_data  = mc_data;
            mc_take   = 1'b1;
        end
    end

    assign wr_ok       = win_valid && !is_hardwired(win_addr);
    assign wr_ptr_next = wr_ptr_reg + (AW + 1)'(fifo_push);
    assign rd_ptr_next = rd_ptr_reg + (AW + 1)'(fifo_pop);

    // Scoreboard next state: a same-cycle issue re-marks the register busy
    assign set_vec = (issue_en && !is_hardwired(issue_addr)) ? (32'd1 << issue_addr) : 32'd0;
    assign clr_vec = win_valid ? (32'd1 << win_addr) : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pending
            assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {ld_addr, ld_data};
        end
    end

    // Pointers, scoreboard and output register; reset discards in-flight results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            pending_reg <= 32'd0;
            we_reg      <= 1'b0;
            addrw_reg   <= 5'd0;
            wdata_reg   <= 32'd0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            pending_reg <= pending_next;
            we_reg      <= wr_ok;
            // Address and data are zeroed when not writing: the register file
            // bypasses wdata on an address match even with we low.
            addrw_reg   <= wr_ok ? win_addr : 5'd0;
            wdata_reg   <= wr_ok ? win_data : 32'd0;
        end
    end

    assign we    = we_reg;
    assign addrw = addrw_reg;
    assign wdata = wdata_reg;

    assign chk_busy1 = pending_reg[chk_addr1] && !is_hardwired(chk_addr1);
    assign chk_busy2 = pending_reg[chk_addr2] && !is_hardwired(chk_addr2);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback with a write-order scoreboard.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        mc_valid, mc_ready;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;
    logic [4:0]  addrw;
    logic [31:0] wdata;
    logic        we;

    int n_vec  = 0;
    int n_fail = 0;

    logic [36:0] exp_q [$];   // expected register-file writes, in order
    logic [36:0] ld_mq [$];   // loads accepted but not yet selected
    logic [31:0] pend_m;      // expected pending-destination set

    regfile_writeback #(.LD_FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .addrw      (addrw),
        .wdata      (wdata),
        .we         (we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic hw(input logic [4:0] a);
        return (a == 5'd0) || (a == 5'd1) || (a == 5'd31);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        mc_valid  = 1'b0;
        issue_en  = 1'b0;
    endtask

    // Advance one clock and compare the registered write port with the scoreboard
    task automatic step();
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("we", 32'(we), 32'd1);
            chk("addrw", 32'(addrw), 32'(e[36:32]));
            chk("wdata", wdata, e[31:0]);
            $display("write r%0d <= %h (dut r%0d <= %h we=%0b)", e[36:32], e[31:0], addrw, wdata, we);
        end else begin
            chk("idle_we", 32'(we), 32'd0);
            chk("idle_addrw", 32'(addrw), 32'd0);
            chk("idle_wdata", wdata, 32'd0);
        end
    endtask

    // One cycle with the currently driven inputs: check handshakes and hazard
    // outputs, predict the winner, then clock and check the write port.
    task automatic cycle(output logic ld_acc, output logic mc_acc);
        logic [36:0] e;
        logic        has;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        exp_ldr, exp_mcr;
        #1;
        exp_ldr = (ld_mq.size() < DEPTH);
        exp_mcr = mc_valid && !alu_valid && (ld_mq.size() == 0);
        chk("ld_ready", 32'(ld_ready), 32'(exp_ldr));
        chk("mc_ready", 32'(mc_ready), 32'(exp_mcr));
        chk("chk_busy1", 32'(chk_busy1), 32'(pend_m[chk_addr1]));
        chk("chk_busy2", 32'(chk_busy2), 32'(pend_m[chk_addr2]));
        has = 1'b0;
        wa  = 5'd0;
        wd  = 32'd0;
        if (alu_valid) begin
            has = 1'b1;
            wa  = alu_addr;
            wd  = alu_data;
        end else if (ld_mq.size() != 0) begin
            e   = ld_mq.pop_front();
            has = 1'b1;
            wa  = e[36:32];
            wd  = e[31:0];
        end else if (mc_valid) begin
            has = 1'b1;
            wa  = mc_addr;
            wd  = mc_data;
        end
        ld_acc = ld_valid && exp_ldr;
        if (ld_acc) ld_mq.push_back({ld_addr, ld_data});
        mc_acc = exp_mcr;
        if (has && !hw(wa)) exp_q.push_back({wa, wd});
        if (has) pend_m[wa] = 1'b0;
        if (issue_en && !hw(issue_addr)) pend_m[issue_addr] = 1'b1;
        step();
    endtask

    logic la, ma;
    int   k, guard, n_acc;

    initial begin
        rst = 1'b1;
        idle_inputs();
        alu_addr = 5'd0; alu_data = 32'd0;
        ld_addr = 5'd0;  ld_data = 32'd0;
        mc_addr = 5'd0;  mc_data = 32'd0;
        issue_addr = 5'd0;
        chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        pend_m = 32'd0;

        // Reset state, including handshakes suppressed while in reset
        #2 rst = 1'b0;
        mc_valid = 1'b1;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addrw", 32'(addrw), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_mc_ready", 32'(mc_ready), 32'd0);
        mc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single ALU write, then idle cycles
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        cycle(la, ma);
        idle_inputs();
        repeat (3) cycle(la, ma);

        // ALU busy for 6 cycles while 5 loads are offered
        k = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'hA000_0000 + 32'(i);
            ld_valid = (k < 5); ld_addr = 5'(20 + k); ld_data = 32'hB000_0000 + 32'(k);
            cycle(la, ma);
            if (la) k++;
        end
        chk("loads_accepted_under_alu", 32'(k), 32'd4);
        alu_valid = 1'b0;
        guard = 0;
        while ((k < 5 || ld_mq.size() != 0) && guard < 20) begin
            ld_valid = (k < 5); ld_addr = 5'(20 + k); ld_data = 32'hB000_0000 + 32'(k);
            cycle(la, ma);
            if (la) k++;
            guard++;
        end
        chk("load_drain_in_bound", 32'(guard < 20), 32'd1);
        idle_inputs();
        cycle(la, ma);

        // Multi-cycle result waits for two buffered loads to drain
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(2 + i); alu_data = 32'hC000_0000 + 32'(i);
            ld_valid = 1'b1; ld_addr = 5'(25 + i); ld_data = 32'hD000_0000 + 32'(i);
            cycle(la, ma);
        end
        idle_inputs();
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h7777_0007;
        n_acc = 0;
        guard = 0;
        while (mc_valid && guard < 10) begin
            cycle(la, ma);
            guard++;
            if (ma) begin
                n_acc++;
                mc_valid = 1'b0;
            end
        end
        chk("mc_accept_count", 32'(n_acc), 32'd1);
        chk("mc_accept_cycle", 32'(guard), 32'd3);
        cycle(la, ma);

        // Hardwired destinations from every source are consumed without a write
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1111_1111;
        cycle(la, ma);
        alu_addr = 5'd31; alu_data = 32'h3131_3131;
        cycle(la, ma);
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 5'd1; ld_data = 32'h0101_0101;
        cycle(la, ma);
        ld_addr = 5'd31; ld_data = 32'h1F1F_1F1F;
        cycle(la, ma);
        ld_valid = 1'b0;
        repeat (2) cycle(la, ma);
        mc_valid = 1'b1; mc_addr = 5'd31; mc_data = 32'hFFFF_0031;
        cycle(la, ma);
        mc_addr = 5'd0; mc_data = 32'hFFFF_0000;
        cycle(la, ma);
        mc_valid = 1'b0;
        cycle(la, ma);

        // Scoreboard: set, clear on writeback, same-cycle re-issue keeps busy
        chk_addr1 = 5'd9; chk_addr2 = 5'd0;
        issue_en = 1'b1; issue_addr = 5'd9;
        cycle(la, ma);
        issue_addr = 5'd0;
        cycle(la, ma);
        issue_en = 1'b0; chk_addr2 = 5'd9;
        cycle(la, ma);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0909_0909;
        cycle(la, ma);
        alu_valid = 1'b0;
        cycle(la, ma);
        issue_en = 1'b1; issue_addr = 5'd9;
        cycle(la, ma);
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0909_AAAA;
        cycle(la, ma);
        issue_en = 1'b0; alu_valid = 1'b0;
        cycle(la, ma);
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h0909_BBBB;
        cycle(la, ma);
        mc_valid = 1'b0; chk_addr2 = 5'd31;
        repeat (2) cycle(la, ma);

        // Asynchronous reset with the FIFO full and destinations pending
        chk_addr1 = 5'd20; chk_addr2 = 5'd23;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hE000_0000 + 32'(i);
            ld_valid = 1'b1; ld_addr = 5'(16 + i); ld_data = 32'hF000_0000 + 32'(i);
            issue_en = 1'b1; issue_addr = 5'(20 + i);
            cycle(la, ma);
        end
        issue_en = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'h0808_0808;
        #1;
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("pending_busy1", 32'(chk_busy1), 32'd1);
        chk("pending_busy2", 32'(chk_busy2), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_addrw", 32'(addrw), 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        chk("arst_ld_ready", 32'(ld_ready), 32'd0);
        chk("arst_busy1", 32'(chk_busy1), 32'd0);
        chk("arst_busy2", 32'(chk_busy2), 32'd0);
        alu_valid = 1'b0;
        #1;
        chk("arst_mc_ready", 32'(mc_ready), 32'd0);
        exp_q.delete();
        ld_mq.delete();
        pend_m = 32'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_we", 32'(we), 32'd0);
        rst = 1'b1;
        repeat (4) cycle(la, ma);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
